// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit_if
// Description : Memory, ALU and register-file control bundle for the CPU
//               control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_control_unit_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              alu_zero;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        alu_op;
    logic [1:0]        rf_raddr_a;
    logic [1:0]        rf_raddr_b;
    logic [1:0]        rf_waddr;
    logic              rf_we;
    logic [1:0]        wb_sel;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] pc;
    logic              zero_flag;
    logic              halted;

    // Control unit side
    modport master (
        input  mem_rdata, mem_ready, alu_zero,
        output mem_addr, mem_rd, mem_wr, alu_op,
        output rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel,
        output imm, pc, zero_flag, halted
    );

    // Datapath / memory side
    modport slave (
        output mem_rdata, mem_ready, alu_zero,
        input  mem_addr, mem_rd, mem_wr, alu_op,
        input  rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel,
        input  imm, pc, zero_flag, halted
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Multi-cycle fetch/decode/execute control FSM for the 8-bit CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cpu_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FETCH2 = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] c_op_ldi = 4'b1000;
    localparam logic [3:0] c_op_ld  = 4'b1001;
    localparam logic [3:0] c_op_st  = 4'b1010;
    localparam logic [3:0] c_op_jmp = 4'b1011;
    localparam logic [3:0] c_op_jz  = 4'b1100;
    localparam logic [3:0] c_op_hlt = 4'b1111;

    localparam logic [1:0] c_wb_alu = 2'b00;
    localparam logic [1:0] c_wb_mem = 2'b01;
    localparam logic [1:0] c_wb_imm = 2'b10;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic [7:0]        imm_q;
    logic              zero_q;

    logic [3:0]        w_opcode;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic              w_is_alu;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_rdata_addr;

    assign w_opcode     = ir_q[7:4];
    assign w_rd         = ir_q[3:2];
    assign w_rs         = ir_q[1:0];
    assign w_is_alu     = ~ir_q[7];
    assign w_pc_inc     = pc_q + ADDR_W'(1);
    assign w_rdata_addr = ADDR_W'(bus.mem_rdata);

    // ------------------------------------------------------------------------
    // Sequencer: state, PC, IR, immediate latch and Z flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
            imm_q   <= 8'h00;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    state_q <= S_FETCH;
                end

                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q    <= bus.mem_rdata;
                        pc_q    <= w_pc_inc;
                        state_q <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (w_is_alu) begin
                        state_q <= S_EXEC;
                    end else begin
                        case (w_opcode)
                            c_op_ldi, c_op_ld, c_op_st,
                            c_op_jmp, c_op_jz: state_q <= S_FETCH2;
                            c_op_hlt:          state_q <= S_HALT;
                            default:           state_q <= S_FETCH;
                        endcase
                    end
                end

                S_FETCH2: begin
                    if (bus.mem_ready) begin
                        imm_q <= bus.mem_rdata;
                        case (w_opcode)
                            c_op_jmp: begin
                                pc_q    <= w_rdata_addr;
                                state_q <= S_FETCH;
                            end
                            c_op_jz: begin
                                pc_q    <= zero_q ? w_rdata_addr : w_pc_inc;
                                state_q <= S_FETCH;
                            end
                            c_op_ldi: begin
                                pc_q    <= w_pc_inc;
                                state_q <= S_EXEC;
                            end
                            default: begin
                                pc_q    <= w_pc_inc;
                                state_q <= S_MEM;
                            end
                        endcase
                    end
                end

                S_EXEC: begin
                    // LDI shares this state but must leave Z untouched
                    if (w_is_alu) begin
                        zero_q <= bus.alu_zero;
                    end
                    state_q <= S_FETCH;
                end

                S_MEM: begin
                    if (bus.mem_ready) begin
                        state_q <= S_FETCH;
                    end
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_START;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Strobe decode from state and IR
    // ------------------------------------------------------------------------
    always_comb begin
        bus.mem_addr   = pc_q;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.alu_op     = 3'b000;
        bus.rf_raddr_a = 2'b00;
        bus.rf_raddr_b = 2'b00;
        bus.rf_waddr   = 2'b00;
        bus.rf_we      = 1'b0;
        bus.wb_sel     = c_wb_alu;

        case (state_q)
            S_FETCH, S_FETCH2: begin
                bus.mem_rd = 1'b1;
            end

            S_EXEC: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = w_rd;
                if (w_is_alu) begin
                    bus.alu_op     = ir_q[6:4];
                    bus.rf_raddr_a = w_rd;
                    bus.rf_raddr_b = w_rs;
                    bus.wb_sel     = c_wb_alu;
                end else begin
                    bus.wb_sel     = c_wb_imm;
                end
            end

            S_MEM: begin
                bus.mem_addr = ADDR_W'(imm_q);
                if (w_opcode == c_op_ld) begin
                    bus.mem_rd   = 1'b1;
                    bus.rf_we    = bus.mem_ready;
                    bus.wb_sel   = c_wb_mem;
                    bus.rf_waddr = w_rd;
                end else begin
                    bus.mem_wr     = 1'b1;
                    bus.rf_raddr_b = w_rs;
                end
            end

            default: begin
            end
        endcase
    end

    assign bus.imm       = imm_q;
    assign bus.pc        = pc_q;
    assign bus.zero_flag = zero_q;
    assign bus.halted    = (state_q == S_HALT);

endmodule
`default_nettype wire
